nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs multi-precision addition of 4*NIBBLES-bit operands using one shared 4-bit ripple_carry_adder slice.
- Each operation walks the operands nibble by nibble, LSB first, and registers the carry between nibbles.
- The adder instance sits outside this block; the controller drives its a/b/c_in and samples its sum/c_out.
- Used wherever a wide add is needed but only one 4-bit adder is budgeted.

---
 rtl/nibble_serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Sequences a 4*NIBBLES-bit add through one external 4-bit ripple-carry
// adder slice. The slice is visited LSB nibble first, and the carry between
// nibbles is held in a register.
// Optional build macro NIBBLE_SERIAL_SUB_EN adds a 'sub' input that turns
// the operation into op_a - op_b (two's complement, c_out=1 means no borrow).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   c_in,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   c_out,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               accept;
  logic               last_nib;
  logic               sub_sel;

  // A request is only honoured while idle; busy/done states ignore start.
  assign accept   = (state == S_IDLE) && start;
  assign last_nib = (idx == IDX_W'(NIBBLES - 1));

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last nibble, DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_nib) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: status flags and adder operands, zero outside RUN.
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IDX_W'(i)) begin
          add_a = a_q[4*i +: 4];
          add_b = b_q[4*i +: 4];
        end
      end
      add_cin = carry;
    end
  end

  // Operand capture on accept; B is stored pre-inverted for subtraction so
  // the RUN datapath is identical for add and subtract.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= sub_sel ? ~op_b : op_b;
    end
  end

  // Nibble index, inter-nibble carry, result and final carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
    end else begin
      if (accept) begin
        idx   <= '0;
        carry <= sub_sel ? 1'b1 : c_in;
      end else if (state == S_RUN) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx == IDX_W'(i)) begin
            result[4*i +: 4] <= add_sum;
          end
        end
        carry <= add_cout;
        if (last_nib) begin
          c_out <= add_cout;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural
// 4-bit adder slice attached to the add_* ports.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        c_in;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  int checks;
  int errors;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .c_in     (c_in),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External 4-bit ripple-carry slice
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, record add_cin per RUN cycle, wait for done.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic [15:0] exp_res,
                       input logic exp_co, input logic [3:0] exp_cin_seq);
    int n;
    int busy_cnt;
    logic [3:0] cs;
    start = 1'b1; op_a = a; op_b = b; c_in = ci; sub = sb;
    tick();
    start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; c_in = ~ci;
    n = 0; busy_cnt = 0; cs = 4'h0;
    while (!done && n < 20) begin
      if (n < 4) cs[n] = add_cin;
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    if (busy) busy_cnt++;
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_busy_cycles"}, busy_cnt, 5);
    chk({tag, "_result"}, {16'h0, result}, {16'h0, exp_res});
    chk({tag, "_c_out"}, {31'h0, c_out}, {31'h0, exp_co});
    chk({tag, "_cin_seq"}, {28'h0, cs}, {28'h0, exp_cin_seq});
    tick();
    chk({tag, "_done_drop"}, {30'h0, busy, done}, 32'h0);
    chk({tag, "_held"}, {15'h0, c_out, result}, {15'h0, exp_co, exp_res});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0; sub = 1'b0;
    #3;
    chk("reset_status", {30'h0, busy, done}, 32'h0);
    chk("reset_result", {15'h0, c_out, result}, 32'h0);
    chk("reset_adder", {23'h0, add_a, add_b, add_cin}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_status", {30'h0, busy, done}, 32'h0);

    // 1 + 2
    do_op("add_small", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 4'b0000);
    // full carry ripple
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1110);
    // A5A5 + 5A5A + 1
    do_op("add_cin", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b1111);

    // start held high across busy with changing operands
    start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; c_in = 1'b0; sub = 1'b0;
    tick();
    chk("b2b_first_nib", {23'h0, add_a, add_b, add_cin}, {23'h0, 4'h4, 4'h1, 1'b0});
    op_a = 16'hFFFF; op_b = 16'hFFFF; c_in = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      tick();
      op_a = op_a ^ 16'h0F0F;
      n++;
    end
    chk("b2b_latency", n, 4);
    chk("b2b_result", {15'h0, c_out, result}, {15'h0, 1'b0, 16'h2345});
    tick();
    chk("b2b_no_accept_in_done", {30'h0, busy, done}, 32'h0);
    op_a = 16'h0100; op_b = 16'h0200; c_in = 1'b0;
    tick();
    chk("b2b_second_accept", {31'h0, busy}, 32'h1);
    chk("b2b_result_kept", {16'h0, result}, 32'h2345);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b2_latency", n, 4);
    chk("b2b2_result", {15'h0, c_out, result}, {15'h0, 1'b0, 16'h0300});
    tick();

    // reset during the second RUN cycle
    start = 1'b1; op_a = 16'h0033; op_b = 16'h0044; c_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("mid_run_idx1", {23'h0, add_a, add_b, add_cin}, {23'h0, 4'h3, 4'h4, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {30'h0, busy, done}, 32'h0);
    chk("mid_rst_result", {15'h0, c_out, result}, 32'h0);
    chk("mid_rst_adder", {23'h0, add_a, add_b, add_cin}, 32'h0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) n++;
      tick();
    end
    chk("mid_rst_no_done", n, 0);
    do_op("add_after_rst", 16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0, 4'b0000);

`ifdef NIBBLE_SERIAL_SUB_EN
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4'b0001);
    do_op("sub_noborrow", 16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 4'b1111);
    do_op("sub0_add", 16'h0009, 16'h0003, 1'b1, 1'b0, 16'h000D, 1'b0, 4'b0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
